keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter ROW_DWELL, default 2: clk1k cycles each keypad row is driven (range 1..15).
REQ-002 Parameter DEBOUNCE_SCANS, default 3: consecutive identical full-scan snapshots required to update key (range 1..7).
REQ-003 Parameter BTN_DEBOUNCE, default 20: consecutive identical samples required to update a button level (range 1..255).
REQ-004 clk1k  input  1  1 kHz scan clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-low, sampled on clk1k.
REQ-006 col_in  input  4  keypad column lines, active-low (low = pressed), pulled up externally.
REQ-007 row_out  output  4  keypad row drive, one-cold (exactly one bit low).
REQ-008 btn_raw  input  2  raw buttons, active-high; bit0 = main, bit1 = switch.
REQ-009 key  output  16  debounced key levels, bit index = row*4 + col, 1 = pressed.
REQ-010 btn_main, btn_switch  output  1 each  debounced button levels, active-high.
REQ-011 key_press  output  1  one-cycle pulse on a new single-key press.
REQ-012 key_code  output  4  index of the key reported by the last key_press.

Function
REQ-013 The scan SHALL drive row r low (row_out = ~(1<<r)) for ROW_DWELL cycles, then advance r = 0,1,2,3,0,... with wrap-around.
REQ-014 On the last dwell cycle of row r, the block SHALL latch ~col_in into snap[r*4+3 : r*4]; a full snapshot completes on the row-3 latch.
REQ-015 On each completed snapshot, the block SHALL set stab_cnt to stab_cnt+1 (saturating at DEBOUNCE_SCANS) if snapshot equals the previous snapshot; otherwise it SHALL set stab_cnt to 1.
REQ-016 The block SHALL load key from the snapshot one cycle after stab_cnt reaches DEBOUNCE_SCANS, and SHALL hold key at all other times.
REQ-017 The block SHALL pulse key_press high for exactly one cycle, coincident with the key update, when the old key was 0 and the new key has exactly one bit set; key_code SHALL take that bit index in the same cycle.
REQ-018 The block SHALL NOT pulse key_press on multi-key values, on release, or on a change between two nonzero values; key_code SHALL hold its value.
REQ-019 Each button SHALL use an independent counter: on each cycle where the sample differs from the output level, the counter increments; the output toggles when the counter reaches BTN_DEBOUNCE, and the counter then clears; any sample equal to the output level SHALL clear the counter.
REQ-020 Glitches shorter than BTN_DEBOUNCE cycles SHALL never change btn_main or btn_switch.
REQ-021 Worst-case key latency from stable contact SHALL be ≤ 4*ROW_DWELL*(DEBOUNCE_SCANS+1)+1 cycles (33 at defaults).

Reset
REQ-022 While rst_n is low at a clk1k edge: row_out = 4'b1110, dwell/row counters = 0, snapshots = 0, stab_cnt = 0, key = 0, key_press = 0, key_code = 0, btn_main = btn_switch = 0, button counters = 0.
REQ-023 Reset asserted mid-scan SHALL discard the partial snapshot; scanning SHALL restart at row 0 on the first cycle after rst_n is released.

Configuration
REQ-024 With macro KEYPAD_GHOST_REJECT_EN defined, a completed snapshot with ≥3 bits set SHALL be discarded: key is held, stab_cnt is cleared to 0, and the previous-snapshot register is left unchanged.
REQ-025 Without KEYPAD_GHOST_REJECT_EN, every snapshot SHALL be processed per REQ-015..REQ-018.

Verification
REQ-026 Key 5 (row1, col1) held low for 100 ms -> key = 16'h0020 within 33 cycles; one key_press with key_code = 5; release -> key = 0 and no pulse.
REQ-027 Key 10 bouncing (toggling every 3 cycles for 15 cycles, then stable) -> exactly one key_press, key_code = 10, key = 16'h0400.
REQ-028 btn_raw[0] high for 10 cycles -> btn_main stays 0; high for 25 cycles -> btn_main = 1 on the 20th cycle after the rise.
REQ-029 Keys 0, 1 and 4 pressed together -> with KEYPAD_GHOST_REJECT_EN, key stays 0 and no pulse; without it, key = 16'h0013 and no pulse.
REQ-030 rst_n low for 1 cycle during row 2 dwell with key 3 held -> row_out = 4'b1110 after reset and key = 0, then key = 16'h0008 within 33 cycles.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan
//   4x4 matrix keypad scanner with whole-matrix snapshot debounce, new single
//   key press detection, and two independently debounced push buttons.
//
//   Optional feature: define KEYPAD_GHOST_REJECT_EN to discard any completed
//   snapshot with three or more keys down (possible matrix ghosting).
//
// Parameters
//   ROW_DWELL       clk1k cycles each row is driven (1..15)
//   DEBOUNCE_SCANS  identical consecutive snapshots needed to update key (1..7)
//   BTN_DEBOUNCE    identical consecutive samples needed to flip a button (1..255)
//
// Ports
//   clk1k       in   1 kHz scan clock, rising edge
//   rst_n       in   synchronous active-low reset
//   col_in      in   [3:0] column lines, low = pressed
//   row_out     out  [3:0] one-cold row drive
//   btn_raw     in   [1:0] raw buttons, bit0 = main, bit1 = switch
//   key         out  [15:0] debounced key levels, bit = row*4 + col
//   btn_main    out  debounced main button
//   btn_switch  out  debounced switch button
//   key_press   out  one-cycle pulse on a new single-key press
//   key_code    out  [3:0] index of the most recently pressed single key
module keypad_scan #(
    parameter int unsigned ROW_DWELL      = 2,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned BTN_DEBOUNCE   = 20
) (
    input  logic        clk1k,
    input  logic        rst_n,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    input  logic [1:0]  btn_raw,
    output logic [15:0] key,
    output logic        btn_main,
    output logic        btn_switch,
    output logic        key_press,
    output logic [3:0]  key_code
);

    localparam int unsigned DWELL_W = 4;
    localparam int unsigned STAB_W  = 3;
    localparam int unsigned BTN_W   = 8;
    localparam int unsigned KEY_W   = 16;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned POP_W   = 5;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
    localparam logic [STAB_W-1:0]  STAB_MAX   = STAB_W'(DEBOUNCE_SCANS);
    localparam logic [BTN_W-1:0]   BTN_LAST   = BTN_W'(BTN_DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } scanStateT;

    // Number of keys down in a snapshot.
    function automatic logic [POP_W-1:0] countOnes(input logic [KEY_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < KEY_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Index of the lowest set bit (only used on one-hot values).
    function automatic logic [CODE_W-1:0] lowestSet(input logic [KEY_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    scanStateT          scanState, scanStateNext;
    logic [DWELL_W-1:0] dwellCnt, dwellCntNext;
    logic [3:0]         rowOut, rowOutNext;
    logic [KEY_W-1:0]   snap, snapNext;
    logic [KEY_W-1:0]   prevSnap, prevSnapNext;
    logic [STAB_W-1:0]  stabCnt, stabCntNext;
    logic               loadPend, loadPendNext;
    logic [KEY_W-1:0]   keyReg, keyNext;
    logic               keyPressReg, keyPressNext;
    logic [CODE_W-1:0]  keyCodeReg, keyCodeNext;
    logic               snapDone;
    logic               ghost;

    logic [1:0]            btnLevel, btnLevelNext;
    logic [1:0][BTN_W-1:0] btnCnt, btnCntNext;

    // Scan sequencing, snapshot debounce and press detection.
    always_comb begin
        scanStateNext = scanState;
        dwellCntNext  = dwellCnt + 1'b1;
        rowOutNext    = rowOut;
        snapNext      = snap;
        prevSnapNext  = prevSnap;
        stabCntNext   = stabCnt;
        loadPendNext  = 1'b0;
        keyNext       = keyReg;
        keyPressNext  = 1'b0;
        keyCodeNext   = keyCodeReg;
        snapDone      = 1'b0;
        ghost         = 1'b0;

        // Columns are latched on the last dwell cycle so they have settled.
        if (dwellCnt >= DWELL_LAST) begin
            dwellCntNext = '0;
            case (scanState)
                ROW0: begin
                    snapNext[3:0] = ~col_in;
                    scanStateNext = ROW1;
                    rowOutNext    = 4'b1101;
                end
                ROW1: begin
                    snapNext[7:4] = ~col_in;
                    scanStateNext = ROW2;
                    rowOutNext    = 4'b1011;
                end
                ROW2: begin
                    snapNext[11:8] = ~col_in;
                    scanStateNext  = ROW3;
                    rowOutNext     = 4'b0111;
                end
                ROW3: begin
                    snapNext[15:12] = ~col_in;
                    scanStateNext   = ROW0;
                    rowOutNext      = 4'b1110;
                    snapDone        = 1'b1;
                end
                default: begin
                    scanStateNext = ROW0;
                    rowOutNext    = 4'b1110;
                end
            endcase
        end

        // A completed snapshot either extends the stable run or restarts it.
        if (snapDone) begin
`ifdef KEYPAD_GHOST_REJECT_EN
            ghost = (countOnes(snapNext) >= POP_W'(3));
`endif
            if (ghost) begin
                stabCntNext = '0;
            end else begin
                prevSnapNext = snapNext;
                if (snapNext != prevSnap) begin
                    stabCntNext = STAB_W'(1);
                end else if (stabCnt < STAB_MAX) begin
                    stabCntNext = stabCnt + 1'b1;
                end
                loadPendNext = (stabCntNext == STAB_MAX);
            end
        end

        // Key update lands one cycle after the run reaches its target.
        if (loadPend) begin
            keyNext = prevSnap;
            if ((keyReg == '0) && (countOnes(prevSnap) == POP_W'(1))) begin
                keyPressNext = 1'b1;
                keyCodeNext  = lowestSet(prevSnap);
            end
        end
    end

    always_ff @(posedge clk1k) begin
        if (!rst_n) begin
            scanState   <= ROW0;
            dwellCnt    <= '0;
            rowOut      <= 4'b1110;
            snap        <= '0;
            prevSnap    <= '0;
            stabCnt     <= '0;
            loadPend    <= 1'b0;
            keyReg      <= '0;
            keyPressReg <= 1'b0;
            keyCodeReg  <= '0;
        end else begin
            scanState   <= scanStateNext;
            dwellCnt    <= dwellCntNext;
            rowOut      <= rowOutNext;
            snap        <= snapNext;
            prevSnap    <= prevSnapNext;
            stabCnt     <= stabCntNext;
            loadPend    <= loadPendNext;
            keyReg      <= keyNext;
            keyPressReg <= keyPressNext;
            keyCodeReg  <= keyCodeNext;
        end
    end

    // Button debounce: count disagreeing samples, flip when the run completes.
    always_comb begin
        btnLevelNext = btnLevel;
        btnCntNext   = '0;
        for (int b = 0; b < 2; b++) begin
            if (btn_raw[b] != btnLevel[b]) begin
                if (btnCnt[b] >= BTN_LAST) begin
                    btnLevelNext[b] = ~btnLevel[b];
                end else begin
                    btnCntNext[b] = btnCnt[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk1k) begin
        if (!rst_n) begin
            btnLevel <= '0;
            btnCnt   <= '0;
        end else begin
            btnLevel <= btnLevelNext;
            btnCnt   <= btnCntNext;
        end
    end

    assign row_out    = rowOut;
    assign key        = keyReg;
    assign key_press  = keyPressReg;
    assign key_code   = keyCodeReg;
    assign btn_main   = btnLevel[0];
    assign btn_switch = btnLevel[1];

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
//   Drives keypad_scan through a simple keypad matrix emulation and compares
//   every sampled cycle against a behavioural model built from the scan
//   timing rules, a history of completed snapshots and per-button run counts.
module tb_keypad_scan;

    localparam int unsigned RD = 2;
    localparam int unsigned NS = 3;
    localparam int unsigned BD = 20;
`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic        clk1k = 1'b0;
    logic        rst_n;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [1:0]  btn_raw;
    logic [15:0] key;
    logic        btn_main;
    logic        btn_switch;
    logic        key_press;
    logic [3:0]  key_code;

    keypad_scan #(
        .ROW_DWELL     (RD),
        .DEBOUNCE_SCANS(NS),
        .BTN_DEBOUNCE  (BD)
    ) dut (
        .clk1k     (clk1k),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .btn_raw   (btn_raw),
        .key       (key),
        .btn_main  (btn_main),
        .btn_switch(btn_switch),
        .key_press (key_press),
        .key_code  (key_code)
    );

    always #5 clk1k = ~clk1k;

    int vectors = 0;
    int miscompares = 0;

    // Physical stimulus: which keys are held, raw button levels.
    logic [15:0] pressed;
    logic [1:0]  btnIn;

    // Reference model state.
    int          scanCycle;
    logic [15:0] mSnap;
    logic [15:0] hist[$];
    logic [15:0] mKey;
    logic        mPress;
    logic [3:0]  mCode;
    bit          mLoadPend;
    logic [15:0] mLoadVal;
    logic [1:0]  mBtn;
    int          mRun[2];

    // Column levels produced by the keypad for the given row drive.
    function automatic logic [3:0] matrixCols(input logic [3:0] rows, input logic [15:0] keys);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!rows[r]) c = c & ~keys[r*4 +: 4];
        end
        return c;
    endfunction

    // Expected {row_out, key, key_press, key_code, btn_switch, btn_main}.
    function automatic logic [26:0] expVec();
        logic [3:0] one;
        int r;
        one = 4'b0001;
        r = (scanCycle / RD) % 4;
        return {~(one << r), mKey, mPress, mCode, mBtn[1], mBtn[0]};
    endfunction

    task automatic modelEdge();
        int  row;
        bit  same;
        if (!rst_n) begin
            scanCycle = 0;
            mSnap = '0;
            hist.delete();
            mKey = '0;
            mPress = 1'b0;
            mCode = '0;
            mLoadPend = 1'b0;
            mLoadVal = '0;
            mBtn = '0;
            mRun[0] = 0;
            mRun[1] = 0;
            return;
        end
        mPress = 1'b0;
        if (mLoadPend) begin
            if (mKey == '0 && $countones(mLoadVal) == 1) begin
                mPress = 1'b1;
                for (int i = 0; i < 16; i++) if (mLoadVal[i]) mCode = 4'(i);
            end
            mKey = mLoadVal;
            mLoadPend = 1'b0;
        end
        row = (scanCycle / RD) % 4;
        if ((scanCycle % RD) == RD - 1) begin
            mSnap[row*4 +: 4] = pressed[row*4 +: 4];
            if (row == 3) begin
                if (GHOST && $countones(mSnap) >= 3) begin
                    hist.delete();
                end else begin
                    hist.push_back(mSnap);
                    if (hist.size() > NS) void'(hist.pop_front());
                    same = 1'b1;
                    foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
                    if (hist.size() == NS && same) begin
                        mLoadPend = 1'b1;
                        mLoadVal = mSnap;
                    end
                end
            end
        end
        scanCycle++;
        for (int b = 0; b < 2; b++) begin
            if (btnIn[b] != mBtn[b]) begin
                mRun[b]++;
                if (mRun[b] >= BD) begin
                    mBtn[b] = ~mBtn[b];
                    mRun[b] = 0;
                end
            end else begin
                mRun[b] = 0;
            end
        end
    endtask

    // One clock: present inputs, take the edge, advance the model, settle.
    task automatic tick();
        col_in  = matrixCols(row_out, pressed);
        btn_raw = btnIn;
        @(posedge clk1k);
        modelEdge();
        #1;
    endtask

    task automatic settle();
        pressed = '0;
        btnIn = '0;
        for (int i = 0; i < 48; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pressed = 16'($urandom);
            btnIn = 2'($urandom);
            tick();
            vectors++;
            if ({row_out, key, key_press, key_code, btn_main, btn_switch} !== {4'b1110, 16'h0000, 1'b0, 4'h0, 2'b00}) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d got row=%b key=%h kp=%b kc=%h bm=%b bs=%b want row=1110 key=0000 kp=0 kc=0 bm=0 bs=0",
                         i, row_out, key, key_press, key_code, btn_main, btn_switch);
            end
        end
        rst_n = 1'b1;
        pressed = '0;
        btnIn = '0;
    endtask

    task automatic test_single_key();
        logic [26:0] obs, want;
        int lat, presses;
        logic [3:0] codeSeen;
        settle();
        pressed = 16'h0020;
        lat = -1;
        presses = 0;
        codeSeen = '0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            obs = {row_out, key, key_press, key_code, btn_switch, btn_main};
            want = expVec();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL single_key_model t=%0t got=%h want=%h", $time, obs, want);
            end
            if (key_press) begin
                presses++;
                codeSeen = key_code;
            end
            if (lat < 0 && key == 16'h0020) lat = i;
        end
        vectors++;
        if (lat < 1 || lat > 33) begin
            miscompares++;
            $display("FAIL key5_latency got=%0d want=1..33", lat);
        end
        vectors++;
        if (presses != 1 || codeSeen !== 4'd5) begin
            miscompares++;
            $display("FAIL key5_press got presses=%0d code=%0d want presses=1 code=5", presses, codeSeen);
        end
        pressed = '0;
        presses = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            obs = {row_out, key, key_press, key_code, btn_switch, btn_main};
            want = expVec();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL release_model t=%0t got=%h want=%h", $time, obs, want);
            end
            if (key_press) presses++;
        end
        vectors++;
        if (key !== 16'h0000 || presses != 0 || key_code !== 4'd5) begin
            miscompares++;
            $display("FAIL key5_release got key=%h presses=%0d code=%0d want key=0000 presses=0 code=5", key, presses, key_code);
        end
    endtask

    task automatic test_bounce();
        logic [26:0] obs, want;
        int presses;
        logic [3:0] codeSeen;
        settle();
        presses = 0;
        codeSeen = '0;
        for (int i = 0; i < 75; i++) begin
            pressed = (i >= 15 || ((i / 3) % 2) == 0) ? 16'h0400 : 16'h0000;
            tick();
            obs = {row_out, key, key_press, key_code, btn_switch, btn_main};
            want = expVec();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL bounce_model t=%0t got=%h want=%h", $time, obs, want);
            end
            if (key_press) begin
                presses++;
                codeSeen = key_code;
            end
        end
        vectors++;
        if (presses != 1 || codeSeen !== 4'd10 || key !== 16'h0400) begin
            miscompares++;
            $display("FAIL key10_bounce got presses=%0d code=%0d key=%h want presses=1 code=10 key=0400", presses, codeSeen, key);
        end
    endtask

    task automatic test_buttons();
        logic [26:0] obs, want;
        logic wantLvl;
        settle();
        btnIn = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            tick();
            vectors++;
            if (btn_main !== 1'b0) begin
                miscompares++;
                $display("FAIL btn_glitch cyc=%0d got=%b want=0", i, btn_main);
            end
        end
        btnIn = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        btnIn = 2'b01;
        for (int i = 1; i <= 25; i++) begin
            tick();
            wantLvl = (i >= 20);
            vectors++;
            if (btn_main !== wantLvl) begin
                miscompares++;
                $display("FAIL btn_main_rise cyc=%0d got=%b want=%b", i, btn_main, wantLvl);
            end
        end
        // Switch: a 19-cycle pulse must not register, a 20-cycle one must.
        for (int len = 19; len <= 20; len++) begin
            btnIn = 2'b01 | 2'b10;
            for (int i = 0; i < len; i++) tick();
            btnIn = 2'b01;
            tick();
            obs = {row_out, key, key_press, key_code, btn_switch, btn_main};
            want = expVec();
            vectors++;
            if (btn_switch !== (len == 20) || obs !== want) begin
                miscompares++;
                $display("FAIL btn_switch_len%0d got sw=%b vec=%h want sw=%b vec=%h", len, btn_switch, obs, (len == 20), want);
            end
            for (int i = 0; i < 25; i++) tick();
        end
    endtask

    task automatic test_ghost();
        logic [26:0] obs, want;
        int presses;
        logic [15:0] wantKey;
        settle();
        pressed = 16'h0013;
        presses = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            obs = {row_out, key, key_press, key_code, btn_switch, btn_main};
            want = expVec();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL ghost_model t=%0t got=%h want=%h", $time, obs, want);
            end
            if (key_press) presses++;
        end
        wantKey = GHOST ? 16'h0000 : 16'h0013;
        vectors++;
        if (key !== wantKey || presses != 0) begin
            miscompares++;
            $display("FAIL three_keys got key=%h presses=%0d want key=%h presses=0", key, presses, wantKey);
        end
    endtask

    task automatic test_reset_midscan();
        logic [26:0] obs, want;
        int n, lat;
        settle();
        pressed = 16'h0008;
        for (int i = 0; i < 40; i++) tick();
        n = 0;
        while (row_out !== 4'b1011 && n < 16) begin
            tick();
            n++;
        end
        vectors++;
        if (row_out !== 4'b1011) begin
            miscompares++;
            $display("FAIL reach_row2 got=%b want=1011", row_out);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (row_out !== 4'b1110 || key !== 16'h0000) begin
            miscompares++;
            $display("FAIL midscan_reset got row=%b key=%h want row=1110 key=0000", row_out, key);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            obs = {row_out, key, key_press, key_code, btn_switch, btn_main};
            want = expVec();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL midscan_model t=%0t got=%h want=%h", $time, obs, want);
            end
            if (lat < 0 && key == 16'h0008) lat = i;
        end
        vectors++;
        if (lat < 1 || lat > 33) begin
            miscompares++;
            $display("FAIL key3_after_reset latency got=%0d want=1..33", lat);
        end
    endtask

    task automatic test_random();
        logic [26:0] obs, want;
        logic [15:0] one16;
        int len;
        one16 = 16'h0001;
        for (int seg = 0; seg < 50; seg++) begin
            case ($urandom_range(0, 3))
                0: pressed = '0;
                1: pressed = one16 << $urandom_range(0, 15);
                2: pressed = (one16 << $urandom_range(0, 15)) | (one16 << $urandom_range(0, 15));
                default: pressed = 16'($urandom) & 16'($urandom) & 16'($urandom);
            endcase
            if ($urandom_range(0, 2) == 0) btnIn = 2'($urandom);
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                tick();
                obs = {row_out, key, key_press, key_code, btn_switch, btn_main};
                want = expVec();
                vectors++;
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL random_model seg=%0d t=%0t got=%h want=%h", seg, $time, obs, want);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pressed = '0;
        btnIn = '0;
        col_in = 4'hF;
        btn_raw = '0;
        test_reset();
        test_single_key();
        test_bounce();
        test_buttons();
        test_ghost();
        test_reset_midscan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog run did not complete");
        $fatal(1, "timeout");
    end

endmodule
